// File: rtl/seg7_sequence_checker_if.sv
// +----------------------------------------------------------------------------+
// | seg7_sequence_checker_if: segment bus in, decoded digit and status out.     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface seg7_sequence_checker_if #(
    parameter int ERR_W = 8
);
    logic [6:0]       seg_in;
    logic             sample_en;
    logic [3:0]       digit;
    logic             digit_valid;
    logic             illegal;
    logic             seq_ok;
    logic             seq_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output seg_in, sample_en,
        input  digit, digit_valid, illegal, seq_ok, seq_err, err_count
    );

    modport slave (
        input  seg_in, sample_en,
        output digit, digit_valid, illegal, seq_ok, seq_err, err_count
    );
endinterface

`default_nettype wire

// File: rtl/seg7_sequence_checker.sv
// +----------------------------------------------------------------------------+
// | seg7_sequence_checker: debounces a 7-segment bus, decodes hex digits and    |
// | checks them against the fixed cycle 0-B-9-6-1-8-2-7.  Rev 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg7_sequence_checker #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input wire                      clk,
    input wire                      rst,
    seg7_sequence_checker_if.slave  bus
);
    localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);
    localparam logic [6:0] BLANK      = 7'h7F;

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Returns {legal, value}; segment order g..a, active low.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40:   decode = {1'b1, 4'h0};
            7'h79:   decode = {1'b1, 4'h1};
            7'h24:   decode = {1'b1, 4'h2};
            7'h30:   decode = {1'b1, 4'h3};
            7'h19:   decode = {1'b1, 4'h4};
            7'h12:   decode = {1'b1, 4'h5};
            7'h02:   decode = {1'b1, 4'h6};
            7'h78:   decode = {1'b1, 4'h7};
            7'h00:   decode = {1'b1, 4'h8};
            7'h10:   decode = {1'b1, 4'h9};
            7'h08:   decode = {1'b1, 4'hA};
            7'h03:   decode = {1'b1, 4'hB};
            7'h46:   decode = {1'b1, 4'hC};
            7'h21:   decode = {1'b1, 4'hD};
            7'h06:   decode = {1'b1, 4'hE};
            7'h0E:   decode = {1'b1, 4'hF};
            default: decode = 5'b0_0000;
        endcase
    endfunction

    function automatic logic [3:0] next_expected(input logic [3:0] e);
        case (e)
            4'h0:    next_expected = 4'hB;
            4'hB:    next_expected = 4'h9;
            4'h9:    next_expected = 4'h6;
            4'h6:    next_expected = 4'h1;
            4'h1:    next_expected = 4'h8;
            4'h8:    next_expected = 4'h2;
            4'h2:    next_expected = 4'h7;
            default: next_expected = 4'h0;
        endcase
    endfunction

    state_t           state_q;
    logic [3:0]       expected_q;
    logic [6:0]       cand_q, cand_d;
    logic [3:0]       stab_cnt_q, stab_cnt_d;
    logic [6:0]       last_acc_q;
    logic             accept;
    logic [4:0]       dec;
    logic [3:0]       digit_q;
    logic             digit_valid_q, illegal_q, seq_ok_q, seq_err_q;
    logic [ERR_W-1:0] err_count_q;

    assign dec = decode(bus.seg_in);

    // Accept only on the sample where the count first reaches the threshold.
    always_comb begin
        cand_d     = cand_q;
        stab_cnt_d = stab_cnt_q;
        accept     = 1'b0;
        if (bus.sample_en) begin
            if (bus.seg_in == cand_q) begin
                if (stab_cnt_q != STABLE_MAX)
                    stab_cnt_d = stab_cnt_q + 4'd1;
            end else begin
                cand_d     = bus.seg_in;
                stab_cnt_d = 4'd1;
            end
            accept = (stab_cnt_d == STABLE_MAX)
                  && ((stab_cnt_q != STABLE_MAX) || (bus.seg_in != cand_q))
                  && (bus.seg_in != last_acc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q     <= BLANK;
            stab_cnt_q <= 4'd0;
        end else begin
            cand_q     <= cand_d;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            expected_q    <= 4'h0;
            last_acc_q    <= BLANK;
            digit_q       <= 4'h0;
            digit_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            seq_ok_q      <= 1'b0;
            seq_err_q     <= 1'b0;
            err_count_q   <= '0;
        end else begin
            digit_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            if (accept) begin
                last_acc_q <= bus.seg_in;
                if (bus.seg_in != BLANK) begin
                    if (!dec[4]) begin
                        illegal_q <= 1'b1;
                        state_q   <= HUNT;
                        seq_ok_q  <= 1'b0;
                        if (err_count_q != '1)
                            err_count_q <= err_count_q + ERR_W'(1);
                    end else begin
                        digit_q       <= dec[3:0];
                        digit_valid_q <= 1'b1;
                        if (state_q == HUNT) begin
                            if (dec[3:0] == 4'h0) begin
                                state_q    <= TRACK;
                                seq_ok_q   <= 1'b1;
                                expected_q <= 4'hB;
                            end
                        end else if (dec[3:0] == expected_q) begin
                            expected_q <= next_expected(expected_q);
                        end else begin
                            seq_err_q <= 1'b1;
                            state_q   <= HUNT;
                            seq_ok_q  <= 1'b0;
                            if (err_count_q != '1)
                                err_count_q <= err_count_q + ERR_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_valid = digit_valid_q;
    assign bus.illegal     = illegal_q;
    assign bus.seq_ok      = seq_ok_q;
    assign bus.seq_err     = seq_err_q;
    assign bus.err_count   = err_count_q;

endmodule

`default_nettype wire

// File: doc/seg7_sequence_checker.md
SEG7_SEQUENCE_CHECKER -- requirements
Module: seg7_sequence_checker

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive equal samples required before a pattern is accepted; legal range 1..15.
REQ-002 Parameter ERR_W, default 8: width of err_count.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 seg_in  input  7  active-low segment bus, bit0=a .. bit6=g (0 = segment lit).
REQ-006 sample_en  input  1  sample strobe; seg_in is examined only in cycles where this is 1.
REQ-007 digit  output  4  most recently accepted legal hex value.
REQ-008 digit_valid  output  1  one-cycle pulse for each newly accepted legal pattern.
REQ-009 illegal  output  1  one-cycle pulse for each accepted pattern not in the decode table.
REQ-010 seq_ok  output  1  level; 1 while in TRACK.
REQ-011 seq_err  output  1  one-cycle pulse on a sequence mismatch.
REQ-012 err_count  output  ERR_W  saturating count of illegal plus seq_err events.

Function
REQ-013 The decode table SHALL be (hex = g..a):
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-014 Stability filter: on a sample_en cycle, a seg_in equal to cand_reg SHALL increment stab_cnt, saturating at STABLE_CYCLES; a differing seg_in SHALL load cand_reg and set stab_cnt=1.
REQ-015 Acceptance: a pattern SHALL be accepted in the sample_en cycle where stab_cnt becomes equal to STABLE_CYCLES, provided it differs from last_acc; it SHALL then be loaded into last_acc.
REQ-016 Holding a pattern beyond acceptance, or re-stabilising on a value equal to last_acc, SHALL NOT produce another accept.
REQ-017 The blank pattern 7F SHALL be loaded into last_acc when accepted but SHALL raise no pulse and leave the FSM state unchanged.
REQ-018 All outputs SHALL be registered: pulses appear exactly one clock after the accepting sample_en cycle; digit updates in the same cycle as digit_valid.
REQ-019 The FSM SHALL have two states, HUNT and TRACK, plus a 4-bit register expected.
REQ-020 The expected-value cycle SHALL be 0 -> B -> 9 -> 6 -> 1 -> 8 -> 2 -> 7 -> 0.
REQ-021 HUNT: an accepted legal digit 0 SHALL move the FSM to TRACK with expected=B; any other legal digit SHALL pulse digit_valid only.
REQ-022 TRACK: an accepted legal digit equal to expected SHALL advance expected per REQ-020 and keep the FSM in TRACK.
REQ-023 TRACK: an accepted legal digit not equal to expected SHALL pulse seq_err, increment err_count and move the FSM to HUNT.
REQ-024 An accepted illegal pattern SHALL pulse illegal, increment err_count, leave digit unchanged and move the FSM to HUNT, in any state.
REQ-025 Resynchronisation: a mismatching digit 0 in TRACK SHALL pulse seq_err and enter HUNT; that digit SHALL NOT re-lock the FSM; a later accepted 0 is required.
REQ-026 err_count SHALL saturate at all-ones, with no wrap.
REQ-027 illegal and seq_err SHALL never pulse in the same cycle.
REQ-028 sample_en=0 SHALL freeze the filter state; pulse outputs SHALL deassert the next clock.
REQ-029 sample_en held at 1 continuously SHALL be legal.

Reset
REQ-030 rst=1 at a clock edge SHALL set:
- digit=0, digit_valid=0, illegal=0, seq_ok=0, seq_err=0, err_count=0
- FSM=HUNT, expected=0, cand_reg=7F, stab_cnt=0, last_acc=7F.
REQ-031 Reset SHALL take priority over sample_en and abort any in-progress stabilisation; no pulse SHALL be issued in the cycle after reset.

Verification
REQ-032 Full cycle: present 40,03,10,02,79,00,24,78,40, each held 4 sample_en cycles -> 9 digit_valid pulses, seq_ok=1 from the first accept onward, err_count=0.
REQ-033 Glitch rejection: 40 for 4 samples, then 03 for 3 samples, then 40 again -> no accept of B, no second accept of 0, seq_ok stays 1.
REQ-034 Mismatch: lock on 0, then present 5 (12) -> seq_err pulse, err_count=1, seq_ok=0; then 0 (40) -> relock, seq_ok=1.
REQ-035 Illegal pattern: present 7E after lock -> illegal pulse, digit unchanged, err_count increments, FSM=HUNT.
REQ-036 Saturation: with ERR_W=2, five alternating illegal/legal accepts -> err_count stops at 3.
REQ-037 Mid-run reset: assert rst during TRACK with 2 samples of stabilisation pending -> all outputs at reset values the next cycle and no pulses.
